// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide scheduler: op encodings,
// default latencies, counter width and small decode helpers.
package md_pkg;

  localparam int OP_W         = 3;
  localparam int CNT_W        = 4;
  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  typedef enum logic [OP_W-1:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  // True for the multi-cycle ops (MULT, MULTU, DIV, DIVU).
  function automatic logic is_long_op(input logic [OP_W-1:0] op);
    return (op[2] == 1'b0);
  endfunction

  // True for the two divide ops.
  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_sched_if.sv
// E/D-stage view of the multiply/divide unit: issue inputs, stall/busy
// status and the architectural HI/LO values.
interface md_sched_if;
  import md_pkg::*;

  logic             start;
  logic [OP_W-1:0]  op;
  logic [31:0]      a;
  logic [31:0]      b;
  logic             md_in_D;
  logic             stall;
  logic             busy;
  logic [31:0]      hi;
  logic [31:0]      lo;

  // Pipeline side: issues ops, consumes stall and HI/LO.
  modport master (
    output start, op, a, b, md_in_D,
    input  stall, busy, hi, lo
  );

  // Scheduler side.
  modport slave (
    input  start, op, a, b, md_in_D,
    output stall, busy, hi, lo
  );

endinterface

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath. res64 is {hi, lo}: the full
// product for multiplies, {remainder, quotient} for divides.
module md_calc
  import md_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     a,
  input  logic [31:0]     b,
  output logic [63:0]     res64,
  output logic            div0
);

  logic signed [63:0] sa64;
  logic signed [63:0] sb64;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] sa;
  logic signed [31:0] sb;
  logic signed [31:0] sq;
  logic signed [31:0] sr;
  logic        [31:0] uq;
  logic        [31:0] ur;
  logic               b_zero;
  logic               s_ovf;

  // Signed and unsigned products; the signed one uses sign-extended 64-bit operands.
  always_comb begin
    sa64   = {{32{a[31]}}, a};
    sb64   = {{32{b[31]}}, b};
    prod_s = sa64 * sb64;
    prod_u = {32'd0, a} * {32'd0, b};
  end

  // Quotient/remainder; zero divisor and the single signed overflow case are special-cased.
  always_comb begin
    sa     = a;
    sb     = b;
    b_zero = (b == 32'd0);
    s_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    sq     = 32'sd0;
    sr     = 32'sd0;
    uq     = 32'd0;
    ur     = 32'd0;
    if (b_zero) begin
      sq = 32'sd0;
      sr = 32'sd0;
      uq = 32'd0;
      ur = 32'd0;
    end else begin
      uq = a / b;
      ur = a % b;
      if (s_ovf) begin
        // Most-negative / -1 wraps back to itself, remainder zero.
        sq = 32'sh8000_0000;
        sr = 32'sd0;
      end else begin
        sq = sa / sb;
        sr = sa % sb;
      end
    end
  end

  // Select the result for the requested op.
  always_comb begin
    res64 = 64'd0;
    div0  = is_div_op(op) && b_zero;
    case (op)
      MD_MULT:  res64 = prod_s;
      MD_MULTU: res64 = prod_u;
      MD_DIV:   res64 = {sr, sq};
      MD_DIVU:  res64 = {ur, uq};
      default:  res64 = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide scheduler and HI/LO owner. Multi-cycle ops compute their
// result at issue, park it in a pending register and commit it to HI/LO when
// the busy counter expires; the stall output keeps dependent D-stage ops back.
module md_sched
  import md_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  md_sched_if.slave  bus
);

  md_state_e        state_reg;
  md_state_e        state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [63:0]      pend_reg;
  logic [63:0]      pend_next;
  logic             pend_wr_reg;
  logic             pend_wr_next;
  logic [31:0]      hi_reg;
  logic [31:0]      hi_next;
  logic [31:0]      lo_reg;
  logic [31:0]      lo_next;
  logic [63:0]      res64;
  logic             div0;
  logic             busy;

  md_calc u_calc (
    .op    (bus.op),
    .a     (bus.a),
    .b     (bus.b),
    .res64 (res64),
    .div0  (div0)
  );

  // State, counter, pending result and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= {CNT_W{1'b0}};
      pend_reg    <= 64'd0;
      pend_wr_reg <= 1'b0;
      hi_reg      <= 32'd0;
      lo_reg      <= 32'd0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      pend_reg    <= pend_next;
      pend_wr_reg <= pend_wr_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
    end
  end

  // Issue decode, busy countdown and commit of the pending result.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    pend_next    = pend_reg;
    pend_wr_next = pend_wr_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            MD_MULT, MD_MULTU: begin
              state_next   = ST_BUSY;
              cnt_next     = CNT_W'(MULT_CYC);
              pend_next    = res64;
              pend_wr_next = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
              state_next   = ST_BUSY;
              cnt_next     = CNT_W'(DIV_CYC);
              pend_next    = res64;
              // A zero divisor runs the full latency but leaves HI/LO untouched.
              pend_wr_next = ~div0;
            end
            MD_MTHI: hi_next = bus.a;
            MD_MTLO: lo_next = bus.a;
            default: state_next = ST_IDLE;
          endcase
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // A start here is shadowed by the stall and is deliberately ignored.
        if (cnt_reg == 4'd1) begin
          state_next = ST_IDLE;
          cnt_next   = {CNT_W{1'b0}};
          if (pend_wr_reg) begin
            hi_next = pend_reg[63:32];
            lo_next = pend_reg[31:0];
          end else begin
            hi_next = hi_reg;
            lo_next = lo_reg;
          end
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = {CNT_W{1'b0}};
      end
    endcase
  end

  assign busy     = (state_reg == ST_BUSY);
  assign bus.busy = busy;
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;

  // Stall also covers the issue cycle so a directly dependent op cannot slip by.
  assign bus.stall = bus.md_in_D & (busy | (bus.start & is_long_op(bus.op)));

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multiply/divide scheduler and HI/LO register owner for the 5-stage pipeline.
- Accepts mult/div/mthi/mtlo issue from the E stage and models fixed multi-cycle latency with a busy counter.
- Drives a stall request into the D-stage hazard logic while any HI/LO-touching instruction sits in D during a busy window.
- Exposes HI/LO to the E-stage mfhi/mflo result mux.

Parameters:
- MULT_CYC, 5, busy cycles for MULT/MULTU (legal range 1..15)
- DIV_CYC, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  E-stage instruction is an md op this cycle (qualified, not bubble)
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
- a  in  32  forwarded rs value from E
- b  in  32  forwarded rt value from E
- md_in_D  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- stall  out  1  hold PC, F/D, and insert bubble into D/E
- busy  out  1  multi-cycle operation in flight
- hi  out  32  architectural HI
- lo  out  32  architectural LO

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: hi=0, lo=0, busy=0, counter=0, state IDLE. stall is combinational and 0 while reset holds inputs low.
- FSM: two states, IDLE and BUSY.
  - IDLE→BUSY: start=1 with op 0-3 sampled at edge t0.
    - Latch the full 64-bit result into a pending register at t0.
    - Load counter with N (MULT_CYC or DIV_CYC).
  - BUSY: busy=1 for exactly N cycles after t0; counter decrements each edge.
  - BUSY→IDLE: at the edge where counter==1, copy pending result to hi/lo. New hi/lo and busy=0 are both visible in the same cycle.
- MTHI/MTLO: start=1 with op 4/5 in IDLE writes a→hi or a→lo at the next edge. No busy, no stall.
- op 6-7 with start=1: no state change.
- Stall rule: stall = md_in_D & (busy | (start & op<=3)).
  - A D-stage mfhi/mflo/md op directly behind a mult/div stalls from the issue cycle itself.
- start while busy: cannot occur (the stall guarantees this). If it does, it is ignored and the bench flags an error.
- Arithmetic:
  - MULT: signed 32x32→64.
  - MULTU: unsigned 32x32→64.
  - In both cases hi=upper 32 bits, lo=lower 32 bits.
  - DIV: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - DIVU: unsigned quotient/remainder.
- Division by zero (b==0): busy sequence runs normally, and hi/lo keep their prior values at commit.
- Signed DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, no trap.
- Reset mid-operation: aborts the operation; the pending result is discarded and all outputs return to reset values on that edge.
- Simultaneous commit edge and new start: not possible (busy blocks issue). A start in the first cycle with busy=0 is accepted.

Decomposition:
- md_pkg holds:
  - op encodings (MD_MULT..MD_MTLO)
  - default cycle counts
  - 4-bit counter width
- One combinational sub-module md_calc(op, a, b → res64, div0) isolates the signed/unsigned multiply and divide arithmetic.
- FSM, counter, pending register, and hi/lo registers live in md_sched.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5, start at t0 → busy high cycles t0+1..t0+5; then hi=0xFFFFFFFF, lo=0xFFFFFFF1, busy=0.
- DIVU a=7, b=2 → after 10 busy cycles, lo=3, hi=1. DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- MULT issued with md_in_D=1 (mflo in D) → stall=1 in the issue cycle and all 5 busy cycles, 0 in the cycle busy falls. With md_in_D=0 → stall stays 0 throughout.
- Preset hi=0x11, lo=0x22 via MTHI/MTLO, then DIV a=9, b=0 → busy 10 cycles; hi=0x11, lo=0x22 unchanged.
- MTHI a=0xDEADBEEF → hi=0xDEADBEEF next cycle, busy never asserted; then DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- MULTU 0xFFFFFFFF*0xFFFFFFFF, reset pulsed for one cycle at t0+2 → busy=0, hi=lo=0 after reset; no late commit at t0+5.
